trng_word_packer: RTL
=====================

# trng_word_packer

Converts the raw entropy bit stream into 32-bit words and writes them into the downstream `fifo32` word buffer. The block applies optional von Neumann debiasing and a repetition-count health test, and packs accepted bits MSB-first. It issues one write pulse per completed word and holds the word while the FIFO reports full. It sits between the entropy source sampler and `fifo32`.

## Interface
- `RCT_LIMIT`, default 32: run of identical raw bits that trips the health test; legal range 2..255.
- `VN_EN`, default 1: 1 enables the von Neumann corrector; 0 makes every raw bit an accepted bit.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run request.
- `raw_bit`  in  1  raw entropy bit.
- `raw_valid`  in  1  `raw_bit` qualifier; at most one bit per cycle.
- `fifo_full`  in  1  full flag from `fifo32`.
- `fail_clear`  in  1  one-cycle request to leave FAIL.
- `fifo_wr_en`  out  1  registered one-cycle write strobe to `fifo32`.
- `fifo_wr_data`  out  32  registered word; stable while `fifo_wr_en`=1 and in HOLD.
- `health_fail`  out  1  sticky health-test failure flag.
- `words_written`  out  16  count of issued write pulses; saturates at 0xFFFF.

## Operation
- States:
  - IDLE: raw input ignored. Moves to COLLECT at the first edge with `enable`=1.
  - COLLECT: accepts raw bits.
  - HOLD: a complete word is waiting for FIFO space.
  - FAIL: health test has tripped.
- Priority at each edge: `rst` > RCT trip > `enable`=0 > normal operation.
- `rst`: state IDLE. `fifo_wr_en`=0, `fifo_wr_data`=0, `health_fail`=0, `words_written`=0. Shift register, bit counter, pair latch and RCT counter all cleared.
- RCT: active in COLLECT and HOLD on every `raw_valid` cycle.
  - Counter = 1 on the first bit, or when the bit differs from the previous raw bit; otherwise counter +1.
  - When the counter reaches `RCT_LIMIT`: `health_fail`<=1 and state becomes FAIL. Partial word and any HOLD word are discarded, and no write is issued.
- VN corrector (`VN_EN`=1):
  - Raw bits form pairs; the first bit is latched.
  - On the second bit: 10 gives accepted bit 1, 01 gives accepted bit 0, 00 and 11 give nothing.
  - Pair latch is cleared on entry to COLLECT and to HOLD.
- Packing: shift left, accepted bit into bit 0. After 32 accepted bits, the first accepted bit is in bit 31.
- Word completion, at the edge the 32nd bit is accepted:
  - `fifo_wr_data` is loaded with the word and the bit counter goes to 0.
  - If `fifo_full`=0: `fifo_wr_en`<=1 and state stays COLLECT.
  - Otherwise state becomes HOLD.
- HOLD:
  - Raw bits are dropped, but the RCT still runs.
  - At the first edge with `fifo_full`=0: `fifo_wr_en`<=1 and state becomes COLLECT.
- `fifo_wr_en` is 0 in every cycle other than those above. `words_written` increments at the edge that sets `fifo_wr_en`.
- `enable`=0 in COLLECT or HOLD: state becomes IDLE, and the partial or held word is discarded. `health_fail` is unchanged.
- FAIL:
  - Only `fail_clear`=1 exits, to IDLE, with `health_fail`<=0 and RCT cleared.
  - `fail_clear` has no effect in any other state. `enable` is ignored in FAIL.

## Timing
- Write latency: `fifo_wr_en` is high in the cycle immediately after the edge that accepts the 32nd bit, when the FIFO is not full. Otherwise it is high in the cycle after the first not-full edge in HOLD.
- Minimum spacing between write pulses is 32 cycles (`VN_EN`=0) or 64 cycles (`VN_EN`=1). This packer is the only FIFO writer, so `fifo_full` cannot rise during a pulse.
- `health_fail` rises in the cycle after the edge where the limiting bit is sampled.
- IDLE to COLLECT takes one edge. Raw bits in the same cycle as that edge are ignored.

## Test plan
- `VN_EN`=1, `enable`=1, `fifo_full`=0, raw sequence 1,0,0,1 repeated 16 times (64 bits) -> exactly one `fifo_wr_en` pulse, cycle after the last bit's edge, `fifo_wr_data`=0xAAAAAAAA, `words_written`=1.
- Same stream with a 0,0 pair and a 1,1 pair inserted after every 8 raw bits -> pairs discarded, word is still 0xAAAAAAAA after 32 valid pairs, single pulse, no `health_fail`.
- `VN_EN`=0, 32 raw bits 0x12345678 MSB-first with `fifo_full`=1 -> no pulse, state HOLD. 10 further raw bits are dropped. Drop `fifo_full` -> pulse next cycle with 0x12345678. The next word begins from the bits after the release.
- `RCT_LIMIT`=32, 32 consecutive raw 1s -> `health_fail`=1 after the 32nd bit, zero pulses. Raw input then ignored. `fail_clear` pulse -> `health_fail`=0, IDLE, then COLLECT resumes normally with `enable`=1.
- `enable` dropped after 20 accepted bits, then reasserted and 32 bits of 0xFFFF0000 pattern (`VN_EN`=0) -> single pulse with 0xFFFF0000, with no leftover bits from the first attempt.
- `rst` asserted for one cycle while in HOLD -> no pulse. Next cycle: `fifo_wr_data`=0, `words_written`=0, `fifo_wr_en`=0, `health_fail`=0, state IDLE.

Source files
------------

// File: rtl/trng_word_packer_if.sv
// Raw entropy input and fifo32 write port of the TRNG word packer.
interface trng_word_packer_if;
  logic        raw_bit;
  logic        raw_valid;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;

  modport master (
    output raw_bit, raw_valid, fifo_full,
    input  fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  raw_bit, raw_valid, fifo_full,
    output fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/trng_word_packer.sv
// Packs debiased, health-tested entropy bits MSB-first into
// 32-bit words and writes them into fifo32.
module trng_word_packer #(
  parameter int RCT_LIMIT = 32,
  parameter bit VN_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               fail_clear,
  trng_word_packer_if.slave  bus,
  output logic               health_fail,
  output logic [15:0]        words_written
);

  typedef enum logic [1:0] {
    IDLE, COLLECT, HOLD, FAIL
  } state_t;

  localparam logic [7:0] LIM = 8'(RCT_LIMIT);

  state_t      state, state_nxt;
  logic [31:0] shreg, word, wr_data;
  logic [4:0]  bit_cnt;
  logic        pair_vld, pair_bit;
  logic [7:0]  rct_cnt, rct_nxt;
  logic        rct_prev;
  logic        rct_act, trip, run;
  logic        acc_vld, acc_bit;
  logic        word_done, do_write;
  logic        pair_clr, wr_en;

  assign bus.fifo_wr_en   = wr_en;
  assign bus.fifo_wr_data = wr_data;

  always_comb begin
    rct_act = (state == COLLECT || state == HOLD)
              && bus.raw_valid;
    rct_nxt = (rct_cnt == 8'd0 || bus.raw_bit != rct_prev)
              ? 8'd1 : rct_cnt + 8'd1;
    trip    = rct_act && (rct_nxt == LIM);
    run     = enable && !trip;
    if (VN_EN) begin
      acc_vld = state == COLLECT && run && bus.raw_valid
                && pair_vld && (pair_bit != bus.raw_bit);
      acc_bit = pair_bit;
    end else begin
      acc_vld = state == COLLECT && run && bus.raw_valid;
      acc_bit = bus.raw_bit;
    end
    word      = {shreg[30:0], acc_bit};
    word_done = acc_vld && (&bit_cnt);
    do_write  = run && !bus.fifo_full
                && (word_done || state == HOLD);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (enable) state_nxt = COLLECT;
      COLLECT: begin
        if (trip)                         state_nxt = FAIL;
        else if (!enable)                 state_nxt = IDLE;
        else if (word_done && bus.fifo_full) state_nxt = HOLD;
      end
      HOLD: begin
        if (trip)                state_nxt = FAIL;
        else if (!enable)        state_nxt = IDLE;
        else if (!bus.fifo_full) state_nxt = COLLECT;
      end
      FAIL: if (fail_clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // pair latch only survives while staying in COLLECT
    pair_clr = (state != COLLECT) || (state_nxt != COLLECT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg         <= '0;
      bit_cnt       <= '0;
      pair_vld      <= 1'b0;
      pair_bit      <= 1'b0;
      rct_cnt       <= '0;
      rct_prev      <= 1'b0;
      wr_en         <= 1'b0;
      wr_data       <= '0;
      health_fail   <= 1'b0;
      words_written <= '0;
    end else begin
      wr_en <= do_write;
      if (do_write && words_written != 16'hFFFF)
        words_written <= words_written + 16'd1;

      if (trip)
        health_fail <= 1'b1;
      else if (state == FAIL && fail_clear)
        health_fail <= 1'b0;

      if (state == FAIL && fail_clear) begin
        rct_cnt <= '0;
      end else if (rct_act) begin
        rct_cnt  <= rct_nxt;
        rct_prev <= bus.raw_bit;
      end

      if (pair_clr) begin
        pair_vld <= 1'b0;
      end else if (VN_EN && run && bus.raw_valid) begin
        pair_vld <= !pair_vld;
        pair_bit <= bus.raw_bit;
      end

      if (acc_vld) shreg <= word;
      if (word_done) wr_data <= word;

      if (state_nxt != COLLECT || word_done)
        bit_cnt <= '0;
      else if (acc_vld)
        bit_cnt <= bit_cnt + 5'd1;
    end
  end

endmodule
